// File: rtl/p3_controller.sv
// p3_controller: command sequencer driving every control input of the
// Simple RISC Machine datapath through a start/done handshake.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               command request, sampled only in IDLE
//   cmd                 00 MOVI, 01 MOV, 10 ALU, 11 CMP
//   rd, rn, rm          register indices
//   imm                 MOVI immediate
//   sh_in, alu_in       shift code for Rm, ALU op for ALU commands
//   datapath_in         immediate presented to the datapath (WIMM only)
//   writenum, readnum   register-file indices
//   write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop
//                       datapath controls
//   busy, done          handshake status (done is a one-cycle pulse)
//
// Build option: P3_CTRL_FLAGS_EN makes ALU commands update status too.

module p3_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [15:0] imm,
    input  logic [1:0]  sh_in,
    input  logic [1:0]  alu_in,
    output logic [15:0] datapath_in,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WIMM, S_LDA, S_LDB, S_EXEC, S_WB, S_DONE
    } state_t;

    localparam logic [1:0] CMD_MOVI = 2'b00;
    localparam logic [1:0] CMD_MOV  = 2'b01;
    localparam logic [1:0] CMD_ALU  = 2'b10;

    typedef struct packed {
        logic [15:0] dp_in;
        logic [2:0]  wnum;
        logic [2:0]  rnum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        busy;
        logic        done;
    } ctl_t;

    state_t      state_q;
    ctl_t        ctl_q;
    logic [1:0]  cmd_q;
    logic [2:0]  rd_q;
    logic [2:0]  rn_q;
    logic [2:0]  rm_q;
    logic [15:0] imm_q;
    logic [1:0]  sh_q;
    logic [1:0]  alu_q;

    function automatic state_t entry(input logic [1:0] c);
        unique case (1'b1)
            (c == CMD_MOVI): entry = S_WIMM;
            (c == CMD_MOV):  entry = S_LDB;
            default:         entry = S_LDA;
        endcase
    endfunction

    function automatic state_t succ(input state_t s, input logic [1:0] c);
        unique case (s)
            S_WIMM:  succ = S_DONE;
            S_LDA:   succ = S_LDB;
            S_LDB:   succ = S_EXEC;
            S_EXEC:  succ = (c == CMD_MOV || c == CMD_ALU) ? S_WB : S_DONE;
            S_WB:    succ = S_DONE;
            default: succ = S_IDLE;
        endcase
    endfunction

    // Outputs for the state being entered, so they appear registered
    // and aligned with that state (Moore behaviour, no live-input paths).
    function automatic ctl_t decode(
        input state_t      s,
        input logic [1:0]  c,
        input logic [2:0]  d,
        input logic [2:0]  n,
        input logic [2:0]  m,
        input logic [15:0] im,
        input logic [1:0]  sh,
        input logic [1:0]  op
    );
        ctl_t o;
        o      = '0;
        o.busy = (s != S_IDLE);
        unique case (s)
            S_WIMM: begin
                o.write = 1'b1;
                o.vsel  = 1'b1;
                o.wnum  = d;
                o.dp_in = im;
            end
            S_LDA: begin
                o.rnum  = n;
                o.loada = 1'b1;
            end
            S_LDB: begin
                o.rnum  = m;
                o.loadb = 1'b1;
            end
            S_EXEC: begin
                o.shift = sh;
                unique case (1'b1)
                    (c == CMD_MOV): begin
                        o.asel  = 1'b1;
                        o.loadc = 1'b1;
                    end
                    (c == CMD_ALU): begin
                        o.aluop = op;
                        o.loadc = 1'b1;
`ifdef P3_CTRL_FLAGS_EN
                        o.loads = 1'b1;
`else
                        o.loads = 1'b0;
`endif
                    end
                    default: begin
                        o.aluop = 2'b01;
                        o.loads = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                o.write = 1'b1;
                o.wnum  = d;
            end
            S_DONE:  o.done = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            cmd_q   <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            imm_q   <= '0;
            sh_q    <= '0;
            alu_q   <= '0;
        end else if (state_q == S_IDLE && start) begin
            cmd_q   <= cmd;
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
            imm_q   <= imm;
            sh_q    <= sh_in;
            alu_q   <= alu_in;
            state_q <= entry(cmd);
            ctl_q   <= decode(entry(cmd), cmd, rd, rn, rm,
                              imm, sh_in, alu_in);
        end else begin
            state_q <= succ(state_q, cmd_q);
            ctl_q   <= decode(succ(state_q, cmd_q), cmd_q, rd_q,
                              rn_q, rm_q, imm_q, sh_q, alu_q);
        end
    end

    assign datapath_in = ctl_q.dp_in;
    assign writenum    = ctl_q.wnum;
    assign readnum     = ctl_q.rnum;
    assign write       = ctl_q.write;
    assign loada       = ctl_q.loada;
    assign loadb       = ctl_q.loadb;
    assign loadc       = ctl_q.loadc;
    assign loads       = ctl_q.loads;
    assign asel        = ctl_q.asel;
    assign bsel        = 1'b0;
    assign vsel        = ctl_q.vsel;
    assign shift       = ctl_q.shift;
    assign ALUop       = ctl_q.aluop;
    assign busy        = ctl_q.busy;
    assign done        = ctl_q.done;

endmodule

// File: tb/tb_p3_controller.sv
// tb_p3_controller: directed bench for p3_controller with a small
// behavioural datapath so register and status results can be checked.

module tb_p3_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  cmd;
    logic [2:0]  rd, rn, rm;
    logic [15:0] imm;
    logic [1:0]  sh_in, alu_in;
    logic [15:0] datapath_in;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, loads;
    logic        asel, bsel, vsel;
    logic [1:0]  shift, ALUop;
    logic        busy, done;

`ifdef P3_CTRL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    p3_controller dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd),
        .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .sh_in(sh_in), .alu_in(alu_in),
        .datapath_in(datapath_in), .writenum(writenum),
        .readnum(readnum), .write(write), .loada(loada),
        .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel),
        .shift(shift), .ALUop(ALUop), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // behavioural datapath
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc, sout, ain, bin, aout;
    logic        z;

    always_comb begin
        sout = rb;
        case (shift)
            2'b01:   sout = {rb[14:0], 1'b0};
            2'b10:   sout = {1'b0, rb[15:1]};
            2'b11:   sout = {rb[15], rb[15:1]};
            default: sout = rb;
        endcase
        ain  = asel ? 16'd0 : ra;
        bin  = bsel ? {11'd0, datapath_in[4:0]} : sout;
        aout = 16'd0;
        case (ALUop)
            2'b00:   aout = ain + bin;
            2'b01:   aout = ain - bin;
            2'b10:   aout = ain & bin;
            default: aout = ~bin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write) rf[writenum] <= vsel ? datapath_in : rc;
        if (loada) ra <= rf[readnum];
        if (loadb) rb <= rf[readnum];
        if (loadc) rc <= aout;
        if (loads) z <= (aout == 16'd0);
    end

    // event counters, read as before/after differences
    int n_done = 0, n_loada = 0, n_write = 0, n_loads = 0, n_bsel = 0;
    always_ff @(posedge clk) begin
        if (done)  n_done  <= n_done + 1;
        if (loada) n_loada <= n_loada + 1;
        if (write) n_write <= n_write + 1;
        if (loads) n_loads <= n_loads + 1;
        if (bsel)  n_bsel  <= n_bsel + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] all_out();
        return {datapath_in, writenum, readnum, write, loada, loadb,
                loadc, loads, asel, bsel, vsel, shift, ALUop, busy, done};
    endfunction

    task automatic issue(input logic [1:0] c, input logic [2:0] d,
                         input logic [2:0] n, input logic [2:0] m,
                         input logic [15:0] im, input logic [1:0] s,
                         input logic [1:0] a);
        cmd = c; rd = d; rn = n; rm = m;
        imm = im; sh_in = s; alu_in = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // edges after the start edge until DONE is observed, then to IDLE
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        tick();
    endtask

    int lat, d0, a0, w0, s0;

    initial begin
        reset_n = 1'b0; start = 1'b1; cmd = 2'b00; rd = 3'd3;
        rn = 3'd0; rm = 3'd0; imm = 16'h0042; sh_in = 2'b00;
        alu_in = 2'b00;
        repeat (2) tick();
        chk("rst_outs", 64'(all_out()), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // MOVI R3 = 0x42, start held across reset release
        reset_n = 1'b1;
        tick();
        start = 1'b0;
        chk("wimm_ctl", {write, vsel, busy}, 3'b111);
        chk("wimm_wnum", 64'(writenum), 64'd3);
        chk("wimm_dpin", 64'(datapath_in), 64'h42);
        tick();
        chk("movi_done", {done, write}, 2'b10);
        chk("done_dpin", 64'(datapath_in), 64'd0);
        tick();
        chk("idle_busy", {busy, done}, 2'b00);
        chk("r3", 64'(rf[3]), 64'h42);

        // MOVI R0=7, R1=2, then ALU R2 = R0 + (R1<<1)
        issue(2'b00, 3'd0, 3'd0, 3'd0, 16'd7, 2'b00, 2'b00);
        wait_done(lat);
        chk("movi_lat", 64'(lat), 64'd1);
        issue(2'b00, 3'd1, 3'd0, 3'd0, 16'd2, 2'b00, 2'b00);
        wait_done(lat);
        d0 = n_done;
        issue(2'b10, 3'd2, 3'd0, 3'd1, 16'hBEEF, 2'b01, 2'b00);
        chk("alu_lda", {loada, loadb, readnum}, {2'b10, 3'd0});
        tick();
        chk("alu_ldb", {loada, loadb, readnum}, {2'b01, 3'd1});
        tick();
        chk("alu_exec", {loadc, loads, asel, shift, ALUop},
            {1'b1, FLAGS, 1'b0, 2'b01, 2'b00});
        tick();
        chk("alu_wb", {write, vsel, writenum}, {2'b10, 3'd2});
        tick();
        chk("alu_done", 64'(done), 64'd1);
        tick();
        chk("r2", 64'(rf[2]), 64'h000B);
        chk("alu_npulse", 64'(n_done - d0), 64'd1);

        // MOV R5 = R1
        a0 = n_loada;
        issue(2'b01, 3'd5, 3'd7, 3'd1, 16'd0, 2'b00, 2'b11);
        chk("mov_ldb", {loadb, readnum}, {1'b1, 3'd1});
        tick();
        chk("mov_exec", {asel, loadc, loads, ALUop}, 5'b11000);
        tick();
        chk("mov_wb", {write, writenum}, {1'b1, 3'd5});
        tick();
        chk("mov_done", 64'(done), 64'd1);
        tick();
        chk("r5", 64'(rf[5]), 64'd2);
        chk("mov_no_lda", 64'(n_loada - a0), 64'd0);

        // CMP R0, R0 then ALU R6 = R0 + R1 (nonzero)
        w0 = n_write; s0 = n_loads;
        issue(2'b11, 3'd3, 3'd0, 3'd0, 16'd0, 2'b00, 2'b10);
        wait_done(lat);
        chk("cmp_lat", 64'(lat), 64'd3);
        chk("cmp_loads", 64'(n_loads - s0), 64'd1);
        chk("cmp_nowrite", 64'(n_write - w0), 64'd0);
        chk("cmp_z", 64'(z), 64'd1);
        issue(2'b10, 3'd6, 3'd0, 3'd1, 16'd0, 2'b00, 2'b00);
        wait_done(lat);
        chk("alu_lat", 64'(lat), 64'd4);
        chk("r6", 64'(rf[6]), 64'd9);
        chk("alu_z", 64'(z), FLAGS ? 64'd0 : 64'd1);

        // restart attempts with rd=6 while busy on ALU R7 = R1 & R1
        d0 = n_done;
        issue(2'b10, 3'd7, 3'd1, 3'd1, 16'd0, 2'b00, 2'b10);
        lat = 0;
        while (done !== 1'b1 && lat < 10) begin
            start = 1'b1; cmd = 2'b00; rd = 3'd6; imm = 16'hFFFF;
            tick();
            lat++;
        end
        start = 1'b0;
        chk("busy_lat", 64'(lat), 64'd4);
        repeat (3) tick();
        chk("busy_idle", 64'(busy), 64'd0);
        chk("r7", 64'(rf[7]), 64'd2);
        chk("r6_kept", 64'(rf[6]), 64'd9);
        chk("busy_npulse", 64'(n_done - d0), 64'd1);

        // reset during EXEC of ALU R4
        issue(2'b00, 3'd4, 3'd0, 3'd0, 16'h1234, 2'b00, 2'b00);
        wait_done(lat);
        d0 = n_done;
        issue(2'b10, 3'd4, 3'd0, 3'd1, 16'd0, 2'b00, 2'b00);
        tick();
        tick();
        chk("abort_exec", 64'(loadc), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_outs", 64'(all_out()), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("r4_kept", 64'(rf[4]), 64'h1234);
        chk("abort_nodone", 64'(n_done - d0), 64'd0);
        issue(2'b00, 3'd4, 3'd0, 3'd0, 16'h00AA, 2'b00, 2'b00);
        wait_done(lat);
        chk("post_lat", 64'(lat), 64'd1);
        chk("r4_new", 64'(rf[4]), 64'hAA);
        chk("bsel_never", 64'(n_bsel), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
